// File: rtl/vram_bank_mux.sv
// vram_bank_mux: NUM_BANKS synchronous dual-port banks behind one bank-addressed
// port pair. Port A is the fixed-latency (2 cycle) render read path, port B is
// the CPU/DMA req/ack path, and a clear engine zero-fills one bank at a time
// through that bank's port B while every other bank stays fully accessible.
//
// Port B handshake: the requester holds b_req with stable b_we/b_bank/b_addr/
// b_byteena/b_wrdata; the request is taken on the rising edge where b_req and
// b_ack are both high. b_ack is withheld only while the addressed bank is being
// cleared. Port A has no handshake: every a_rd is taken, one per cycle.
module vram_bank_mux #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_rd,
  input  logic [BANK_W-1:0]   a_bank,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic                a_valid,
  output logic [DATA_W-1:0]   a_rddata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [BANK_W-1:0]   b_bank,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_byteena,
  input  logic [DATA_W-1:0]   b_wrdata,
  output logic                b_ack,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rddata,
  input  logic                clr_start,
  input  logic [BANK_W-1:0]   clr_bank,
  output logic                clr_busy,
  output logic                clr_done,
  output logic [1:0]          clr_state_dbg
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [BANK_W:0] NB_L = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_BUSY = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  clr_state_e          clr_state_q, clr_state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic [BANK_W-1:0]   clr_bank_q, clr_bank_d;
  logic                clr_oor;
  logic                b_fire;

  logic                a_v1_q, a_v1_d;
  logic [BANK_W-1:0]   a_bank1_q, a_bank1_d;
  logic                a_valid_q, a_valid_d;
  logic [DATA_W-1:0]   a_rddata_q, a_rddata_d;
  logic                b_v1_q, b_v1_d;
  logic [BANK_W-1:0]   b_bank1_q, b_bank1_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   b_rddata_q, b_rddata_d;

  logic [DATA_W-1:0]   a_word [NUM_BANKS];
  logic [DATA_W-1:0]   b_word [NUM_BANKS];
  logic [DATA_W-1:0]   a_sel, b_sel;

  // Port B is blocked only for the bank the clear engine currently owns.
  always_comb begin
    b_ack   = b_req && !(clr_busy && (b_bank == clr_bank_q));
    b_fire  = b_req && b_ack;
    clr_oor = {1'b0, clr_bank} >= NB_L;
  end

  // Bank array. An out-of-range bank number matches no bank, so such writes
  // vanish and such reads see the zero default of the output mux below.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_dout;
    logic [DATA_W-1:0] b_dout;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BE_W-1:0]   wr_be;
    logic [DATA_W-1:0] wr_data;

    // Write-port mux: the clear engine owns port B of its bank while busy.
    always_comb begin
      if (clr_busy && (clr_bank_q == BANK_W'(g))) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q[ADDR_W-1:0];
        wr_be   = '1;
        wr_data = '0;
      end else begin
        wr_en   = b_fire && b_we && (b_bank == BANK_W'(g));
        wr_addr = b_addr;
        wr_be   = b_byteena;
        wr_data = b_wrdata;
      end
    end

    // Synchronous RAM: reads return pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
      if (a_rd && (a_bank == BANK_W'(g))) a_dout <= mem[a_addr];
      if (b_fire && !b_we && (b_bank == BANK_W'(g))) b_dout <= mem[b_addr];
      if (wr_en) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end

    assign a_word[g] = a_dout;
    assign b_word[g] = b_dout;
  end

  // Clear FSM next state: start only from IDLE with a real bank, run DEPTH writes.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_bank_d  = clr_bank_q;
    case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start && !clr_oor) begin
          clr_state_d = CLR_BUSY;
          clr_cnt_d   = '0;
          clr_bank_d  = clr_bank;
        end
      end
      CLR_BUSY: begin
        clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
        if (clr_cnt_d[ADDR_W]) clr_state_d = CLR_DONE;
      end
      CLR_DONE: clr_state_d = CLR_IDLE;
      default:  clr_state_d = CLR_IDLE;
    endcase
  end

  // Clear FSM outputs decoded from the state register.
  always_comb begin
    clr_busy      = (clr_state_q == CLR_BUSY);
    clr_done      = (clr_state_q == CLR_DONE);
    clr_state_dbg = clr_state_q;
  end

  // Read pipelines: stage 1 is the RAM access, stage 2 the bank select.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int g = 0; g < NUM_BANKS; g++) begin
      if (a_bank1_q == BANK_W'(g)) a_sel = a_word[g];
      if (b_bank1_q == BANK_W'(g)) b_sel = b_word[g];
    end
    a_v1_d     = a_rd;
    a_bank1_d  = a_bank;
    a_valid_d  = a_v1_q;
    a_rddata_d = a_v1_q ? a_sel : '0;
    b_v1_d     = b_fire && !b_we;
    b_bank1_d  = b_bank;
    b_rvalid_d = b_v1_q;
    b_rddata_d = b_v1_q ? b_sel : '0;
  end

  // State register for the clear FSM and both read pipelines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state_q <= CLR_IDLE;
      clr_cnt_q   <= '0;
      clr_bank_q  <= '0;
      a_v1_q      <= 1'b0;
      a_bank1_q   <= '0;
      a_valid_q   <= 1'b0;
      a_rddata_q  <= '0;
      b_v1_q      <= 1'b0;
      b_bank1_q   <= '0;
      b_rvalid_q  <= 1'b0;
      b_rddata_q  <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_bank_q  <= clr_bank_d;
      a_v1_q      <= a_v1_d;
      a_bank1_q   <= a_bank1_d;
      a_valid_q   <= a_valid_d;
      a_rddata_q  <= a_rddata_d;
      b_v1_q      <= b_v1_d;
      b_bank1_q   <= b_bank1_d;
      b_rvalid_q  <= b_rvalid_d;
      b_rddata_q  <= b_rddata_d;
    end
  end

  assign a_valid  = a_valid_q;
  assign a_rddata = a_rddata_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rddata = b_rddata_q;

endmodule

// File: tb/tb_vram_bank_mux.sv
// Bench for vram_bank_mux: a 4-bank build checked cycle by cycle against an
// array/queue reference model, plus a 3-bank build for out-of-range banks.
`timescale 1ns/1ps
module tb_vram_bank_mux;
  localparam int NB = 4, DW = 32, AW = 11, BW = 2, DEPTH = 2048;
  localparam int AW3 = 4, DEPTH3 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 banks) ----------------
  logic          a_rd = 0;
  logic [BW-1:0] a_bank = 0;
  logic [AW-1:0] a_addr = 0;
  logic          a_valid;
  logic [DW-1:0] a_rddata;
  logic          b_req = 0, b_we = 0;
  logic [BW-1:0] b_bank = 0;
  logic [AW-1:0] b_addr = 0;
  logic [3:0]    b_byteena = 0;
  logic [DW-1:0] b_wrdata = 0;
  logic          b_ack, b_rvalid;
  logic [DW-1:0] b_rddata;
  logic          clr_start = 0;
  logic [BW-1:0] clr_bank = 0;
  logic          clr_busy, clr_done;
  logic [1:0]    clr_state_dbg;

  vram_bank_mux #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_rd(a_rd), .a_bank(a_bank), .a_addr(a_addr), .a_valid(a_valid), .a_rddata(a_rddata),
    .b_req(b_req), .b_we(b_we), .b_bank(b_bank), .b_addr(b_addr), .b_byteena(b_byteena),
    .b_wrdata(b_wrdata), .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rddata(b_rddata),
    .clr_start(clr_start), .clr_bank(clr_bank), .clr_busy(clr_busy), .clr_done(clr_done),
    .clr_state_dbg(clr_state_dbg)
  );

  // ---------------- 3-bank DUT for out-of-range banks ----------------
  logic           c_a_rd = 0;
  logic [1:0]     c_a_bank = 0;
  logic [AW3-1:0] c_a_addr = 0;
  logic           c_a_valid;
  logic [DW-1:0]  c_a_rddata;
  logic           c_b_req = 0, c_b_we = 0;
  logic [1:0]     c_b_bank = 0;
  logic [AW3-1:0] c_b_addr = 0;
  logic [3:0]     c_b_byteena = 0;
  logic [DW-1:0]  c_b_wrdata = 0;
  logic           c_b_ack, c_b_rvalid;
  logic [DW-1:0]  c_b_rddata;
  logic           c_clr_start = 0;
  logic [1:0]     c_clr_bank = 0;
  logic           c_clr_busy, c_clr_done;
  logic [1:0]     c_clr_state_dbg;

  vram_bank_mux #(.NUM_BANKS(3), .DATA_W(DW), .ADDR_W(AW3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_rd(c_a_rd), .a_bank(c_a_bank), .a_addr(c_a_addr), .a_valid(c_a_valid), .a_rddata(c_a_rddata),
    .b_req(c_b_req), .b_we(c_b_we), .b_bank(c_b_bank), .b_addr(c_b_addr), .b_byteena(c_b_byteena),
    .b_wrdata(c_b_wrdata), .b_ack(c_b_ack), .b_rvalid(c_b_rvalid), .b_rddata(c_b_rddata),
    .clr_start(c_clr_start), .clr_bank(c_clr_bank), .clr_busy(c_clr_busy), .clr_done(c_clr_done),
    .clr_state_dbg(c_clr_state_dbg)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } exp_t;

  logic [DW-1:0] mem_m [NB][DEPTH];
  bit            kn    [NB][DEPTH];
  exp_t          a_exp_q[$];
  exp_t          b_exp_q[$];
  bit            clr_act = 0;
  int            clr_bk = 0;
  int            clr_ptr = 0;
  int            done_due = -10;
  int            cyc = 0;

  // Model: one step per rising edge; reads see the memory before this edge's writes.
  always @(posedge clk) begin
    bit   idle_before, fire;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      a_exp_q.delete();
      b_exp_q.delete();
      clr_act  = 0;
      done_due = -10;
    end else begin
      idle_before = !clr_act && (done_due != cyc - 1);
      fire = b_req && !(clr_act && (int'(b_bank) == clr_bk));
      if (a_rd) begin
        e.due = cyc + 1;
        e.known = kn[a_bank][a_addr];
        e.data = mem_m[a_bank][a_addr];
        a_exp_q.push_back(e);
      end
      if (fire && !b_we) begin
        e.due = cyc + 1;
        e.known = kn[b_bank][b_addr];
        e.data = mem_m[b_bank][b_addr];
        b_exp_q.push_back(e);
      end
      if (fire && b_we) begin
        for (int i = 0; i < 4; i++)
          if (b_byteena[i]) mem_m[b_bank][b_addr][i*8 +: 8] = b_wrdata[i*8 +: 8];
        if (b_byteena == 4'hF) kn[b_bank][b_addr] = 1;
      end
      if (clr_act) begin
        mem_m[clr_bk][clr_ptr] = '0;
        kn[clr_bk][clr_ptr] = 1;
        clr_ptr++;
        if (clr_ptr == DEPTH) begin
          clr_act  = 0;
          done_due = cyc;
        end
      end
      if (idle_before && clr_start) begin
        clr_act = 1;
        clr_bk  = int'(clr_bank);
        clr_ptr = 0;
      end
    end
  end

  // Scoreboard: compare every output of the 4-bank DUT mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_av, exp_bv;
    if (!rst_n) begin
      check("rst_a_valid", a_valid, 0);
      check("rst_a_rddata", a_rddata, 0);
      check("rst_b_rvalid", b_rvalid, 0);
      check("rst_b_rddata", b_rddata, 0);
      check("rst_clr_busy", clr_busy, 0);
      check("rst_clr_done", clr_done, 0);
    end else begin
      exp_av = (a_exp_q.size() > 0) && (a_exp_q[0].due == cyc);
      check("a_valid", a_valid, exp_av);
      if (exp_av) begin
        e = a_exp_q.pop_front();
        if (e.known) check("a_rddata", a_rddata, e.data);
      end
      exp_bv = (b_exp_q.size() > 0) && (b_exp_q[0].due == cyc);
      check("b_rvalid", b_rvalid, exp_bv);
      if (exp_bv) begin
        e = b_exp_q.pop_front();
        if (e.known) check("b_rddata", b_rddata, e.data);
      end
      check("b_ack", b_ack, b_req && !(clr_act && (int'(b_bank) == clr_bk)));
      check("clr_busy", clr_busy, clr_act);
      check("clr_done", clr_done, done_due == cyc);
    end
  end

  // Event counters used by the directed checks.
  int busy_cnt = 0, done_cnt = 0, av_cnt = 0, c_busy_cnt = 0, c_done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      busy_cnt   += int'(clr_busy);
      done_cnt   += int'(clr_done);
      av_cnt     += int'(a_valid);
      c_busy_cnt += int'(c_clr_busy);
      c_done_cnt += int'(c_clr_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int waited);
    waited = 0;
    @(negedge clk);
    while (!b_ack && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!b_ack) check("b_ack_timeout", b_ack, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic b_write(input int bank, input int addr, input logic [3:0] be, input logic [DW-1:0] d);
    int w;
    b_req = 1; b_we = 1; b_bank = BW'(bank); b_addr = AW'(addr);
    b_byteena = be; b_wrdata = d;
    wait_ack(w);
    b_req = 0; b_we = 0;
  endtask

  task automatic b_read(input int bank, input int addr, output logic [DW-1:0] d, output int waited);
    b_req = 1; b_we = 0; b_bank = BW'(bank); b_addr = AW'(addr);
    wait_ack(waited);
    b_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("b_read_rvalid", b_rvalid, 1);
    d = b_rddata;
    tick();
  endtask

  task automatic a_read(input int bank, input int addr, output logic [DW-1:0] d);
    a_rd = 1; a_bank = BW'(bank); a_addr = AW'(addr);
    tick();
    a_rd = 0;
    @(posedge clk);
    @(negedge clk);
    check("a_read_valid", a_valid, 1);
    d = a_rddata;
    tick();
  endtask

  task automatic a_stream(input int bank, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      a_rd = 1; a_bank = BW'(bank); a_addr = AW'(start + i);
      tick();
    end
    a_rd = 0;
    repeat (3) tick();
  endtask

  function automatic logic [DW-1:0] fill0(input int i);
    return 32'h5A01_0000 | DW'(i);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int w, b0, d0, v0;

    repeat (3) tick();
    check("reset_a_valid", a_valid, 0);
    check("reset_clr_busy", clr_busy, 0);
    check("reset_b_rvalid", b_rvalid, 0);
    rst_n = 1;
    tick();

    // Byte-enable merge, read back on both ports.
    b_write(2, 'h10, 4'hF, 32'hDEADBEEF);
    b_write(2, 'h10, 4'h1, 32'h000000AA);
    a_read(2, 'h10, d);
    check("byteena_merge_a", d, 32'hDEADBEAA);
    b_read(2, 'h10, d, w);
    check("byteena_merge_b", d, 32'hDEADBEAA);

    // Same-edge read/write collision, then read one edge later.
    b_write(0, 5, 4'hF, 32'h0);
    a_rd = 1; a_bank = 0; a_addr = 5;
    b_req = 1; b_we = 1; b_bank = 0; b_addr = 5; b_byteena = 4'hF; b_wrdata = 32'h12345678;
    tick();
    b_req = 0; b_we = 0;
    tick();
    a_rd = 0;
    @(negedge clk);
    check("collision_old", a_rddata, 32'h0);
    @(negedge clk);
    check("collision_new", a_rddata, 32'h12345678);
    tick();

    // Randomized traffic on a small window of every bank.
    for (int bk = 0; bk < NB; bk++)
      for (int ad = 0; ad < 16; ad++) b_write(bk, ad, 4'hF, $urandom);
    for (int i = 0; i < 400; i++) begin
      a_rd = 1'($urandom_range(0, 1));
      a_bank = BW'($urandom_range(0, NB - 1));
      a_addr = AW'($urandom_range(0, 15));
      b_req = 1'($urandom_range(0, 1));
      b_we = 1'($urandom_range(0, 1));
      b_bank = BW'($urandom_range(0, NB - 1));
      b_addr = AW'($urandom_range(0, 15));
      b_byteena = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      b_wrdata = $urandom;
      tick();
    end
    a_rd = 0; b_req = 0; b_we = 0;
    repeat (3) tick();

    // Clear of bank 1 while other banks stay accessible.
    for (int i = 0; i < DEPTH; i++) b_write(1, i, 4'hF, 32'hFFFFFFFF);
    b0 = busy_cnt; d0 = done_cnt;
    clr_bank = 1; clr_start = 1;
    tick();
    clr_start = 0;
    b_req = 1; b_we = 1; b_bank = 3; b_addr = 7; b_byteena = 4'hF; b_wrdata = 32'hCAFEF00D;
    @(negedge clk);
    check("clear_other_bank_ack", b_ack, 1);
    tick();
    b_req = 0; b_we = 0;
    b_read(1, 3, d, w);
    check("blocked_ack_after_done", done_cnt - d0, 1);
    check("blocked_read_zero", d, 32'h0);
    repeat (3) tick();
    check("clear_busy_cycles", busy_cnt - b0, DEPTH);
    check("clear_done_pulses", done_cnt - d0, 1);
    a_stream(1, 0, DEPTH);
    a_read(3, 7, d);
    check("clear_other_bank_data", d, 32'hCAFEF00D);

    // Reset 100 cycles into a clear of bank 0.
    for (int i = 0; i < DEPTH; i++) b_write(0, i, 4'hF, fill0(i));
    d0 = done_cnt;
    clr_bank = 0; clr_start = 1;
    tick();
    clr_start = 0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    check("abort_clr_busy", clr_busy, 0);
    check("abort_clr_done", clr_done, 0);
    check("abort_a_valid", a_valid, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    a_stream(0, 0, DEPTH);
    a_read(0, 98, d);
    check("abort_last_zeroed", d, 32'h0);
    a_read(0, 99, d);
    check("abort_first_kept", d, fill0(99));

    // Streaming port A reads for 64 cycles.
    for (int i = 0; i < 64; i++) b_write(2, i, 4'hF, 32'h0200_0000 + 32'(i) * 32'h101);
    v0 = av_cnt;
    a_stream(2, 0, 64);
    check("stream_valid_count", av_cnt - v0, 64);

    // Out-of-range bank on the 3-bank build.
    c_b_req = 1; c_b_we = 1; c_b_bank = 0; c_b_addr = 2; c_b_byteena = 4'hF; c_b_wrdata = 32'h11111111;
    tick();
    c_b_bank = 3; c_b_wrdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("oor_write_ack", c_b_ack, 1);
    tick();
    c_b_req = 0; c_b_we = 0;
    c_a_rd = 1; c_a_bank = 3; c_a_addr = 2;
    tick();
    c_a_bank = 0;
    tick();
    c_a_rd = 0;
    @(negedge clk);
    check("oor_a_valid", c_a_valid, 1);
    check("oor_a_data", c_a_rddata, 32'h0);
    @(negedge clk);
    check("oor_write_dropped", c_a_rddata, 32'h11111111);
    tick();
    c_b_req = 1; c_b_bank = 3; c_b_addr = 2;
    @(negedge clk);
    check("oor_read_ack", c_b_ack, 1);
    tick();
    c_b_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("oor_b_rvalid", c_b_rvalid, 1);
    check("oor_b_data", c_b_rddata, 32'h0);
    tick();
    c_clr_bank = 3; c_clr_start = 1;
    tick();
    c_clr_start = 0;
    @(negedge clk);
    check("oor_clr_ignored", c_clr_busy, 0);
    tick();
    b0 = c_busy_cnt; d0 = c_done_cnt;
    c_clr_bank = 0; c_clr_start = 1;
    tick();
    c_clr_start = 0;
    repeat (5) tick();
    c_clr_start = 1;
    tick();
    c_clr_start = 0;
    repeat (DEPTH3 + 6) tick();
    check("restart_ignored_busy", c_busy_cnt - b0, DEPTH3);
    check("restart_ignored_done", c_done_cnt - d0, 1);

    repeat (4) tick();
    check("a_queue_drained", a_exp_q.size(), 0);
    check("b_queue_drained", b_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_bank_mux.md
# vram_bank_mux

Parametrised multi-bank dual-port VRAM subsystem for the PPU: NUM_BANKS identical synchronous dual-port banks behind a unified, bank-addressed port pair. Port A is the PPU render read path with fixed 2-cycle latency. Port B is the CPU/DMA access path with a req/ack handshake. A per-bank hardware clear engine zero-fills one bank while the other banks stay fully accessible.

## Interface
- NUM_BANKS, 4: number of banks (tile, pattern, palette, sprite in the default build); ≥1.
- DATA_W, 32: bank word width; multiple of 8.
- ADDR_W, 11: word address width per bank; DEPTH = 2**ADDR_W.
- BANK_W, $clog2(NUM_BANKS) (min 1): bank select width.
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- a_rd  in  1  port A read request; one per cycle, no backpressure.
- a_bank  in  BANK_W  port A bank select.
- a_addr  in  ADDR_W  port A word address.
- a_valid  out  1  port A read data valid.
- a_rddata  out  DATA_W  port A read data.
- b_req  in  1  port B request; held until b_ack.
- b_we  in  1  port B write (1) or read (0).
- b_bank  in  BANK_W  port B bank select.
- b_addr  in  ADDR_W  port B word address.
- b_byteena  in  DATA_W/8  port B byte enables (writes only).
- b_wrdata  in  DATA_W  port B write data.
- b_ack  out  1  request accepted this cycle.
- b_rvalid  out  1  port B read data valid.
- b_rddata  out  DATA_W  port B read data.
- clr_start  in  1  start a zero-fill of bank clr_bank.
- clr_bank  in  BANK_W  bank to clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when a clear completes.

## Operation
- Reset: a_valid, a_rddata, b_rvalid, b_rddata, clr_busy, clr_done all 0. Clear FSM to IDLE, clear counter 0. Bank contents are not reset.
- Port A: a_rd sampled at edge E0 and steered to bank a_bank; data is registered out after E1. It never stalls, including during a clear; it returns whatever the bank holds at access time.
- Port B: b_ack = b_req and not (clr_busy and b_bank == latched clear bank). The handshake completes on an edge where b_req and b_ack are both high. A write applies b_wrdata only to bytes with b_byteena set. A read returns data with b_rvalid.
- Out-of-range bank (≥ NUM_BANKS):
  - port A returns 0 with a_valid;
  - port B is acked; writes are dropped and reads return 0;
  - clr_start is ignored.
- Clear FSM:
  - IDLE --clr_start (valid bank)--> CLEAR: latch the bank and set the counter to 0.
  - CLEAR writes all-zero, full byte enables, to counter address each cycle using the bank's port B, and increments the counter.
  - After writing address DEPTH-1, CLEAR --> DONE.
  - DONE: assert clr_done for one cycle, then return to IDLE.
  - clr_busy is high in CLEAR only. clr_start outside IDLE is ignored.
- Collisions:
  - A port A read and a port B/clear write to the same bank and address sampled at the same edge: port A returns the old data.
  - A read sampled one edge later sees the new data.
- Reset mid-clear aborts immediately. Already-zeroed words stay zero, the remainder is untouched, and no clr_done is pulsed.

## Timing
- Port A: a_rd in cycle t gives a_valid=1 and a_rddata in cycle t+2. The pipeline is fully throughput-1.
- Port B: ack in cycle t. A write is visible to reads sampled at t+1 or later. A read gives b_rvalid in t+2. Back-to-back acks are allowed every cycle.
- Clear: clr_start sampled at edge in cycle t, so clr_busy is high in cycles t+1 .. t+DEPTH and clr_done pulses in cycle t+DEPTH+1.
- A blocked port B request to the clearing bank is acked in cycle t+DEPTH+1 or later, once clr_busy is low.
- Arithmetic: the clear counter is ADDR_W+1 bits so that the terminal count is detected without wrap. The bank decode is a full compare on BANK_W bits.

## Test plan
- Reset, then port B writes 0xDEADBEEF to bank 2 addr 0x10 (byteena 4'hF). Then port B writes 0x000000AA with byteena 4'h1. Port A read of bank 2 addr 0x10 must return 0xDEADBEAA at t+2 with a_valid.
- Same-edge port A read and port B write (0x12345678) to bank 0 addr 5, which holds 0: port A returns 0. A port A read in the next cycle returns 0x12345678.
- Fill bank 1 with 0xFFFFFFFF, then pulse clr_start with clr_bank=1:
  - clr_busy is high exactly 2048 cycles, then clr_done pulses once;
  - a port B write to bank 3 during the clear is acked immediately;
  - a port B request to bank 1 is held unacked until after clr_done;
  - every bank 1 word then reads 0.
- Assert rst_n low 100 cycles into a bank 0 clear: all outputs are 0 and no clr_done. Addresses 0..98 read 0 and the remaining words keep their prior nonzero contents.
- Out-of-range bank (NUM_BANKS=3, bank 3):
  - port B write is acked and dropped, port A read returns 0;
  - clr_start with clr_bank=3 leaves clr_busy low;
  - clr_start while clr_busy=1 does not restart the clear.
- Streaming port A reads on every cycle for 64 cycles: a_valid is high continuously from cycle 2, and the data matches the addresses in order.
